// File: rtl/pe_noc_interface.sv
// pe_noc_interface: network interface between one PE and one leaf port of the BTree NoC.
// TX builds {dest, data} flits into a FWFT FIFO; RX filters flits by address and buffers payloads.

module pe_noc_fifo #(
   parameter int unsigned Width = 36,
   parameter int unsigned Depth = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [Width-1:0] wr_data,
   input  logic             rd_en,
   output logic [Width-1:0] rd_data,
   output logic             rd_valid,
   output logic             wr_ready
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic [CntW-1:0]  count;
   logic [CntW-1:0]  count_next;

   // Occupancy after this edge; push and pop together leave it unchanged.
   always_comb begin
      count_next = count + CntW'(wr_en) - CntW'(rd_en);
   end

   // Head entry falls through to the output.
   assign rd_data = mem[rd_ptr];

   // Storage, pointers (wrap naturally at power-of-two depth) and registered flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < Depth; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
         wr_ready <= 1'b0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + PtrW'(1);
         end
         if (rd_en) rd_ptr <= rd_ptr + PtrW'(1);
         count    <= count_next;
         rd_valid <= (count_next != CntW'(0));
         wr_ready <= (count_next != CntW'(Depth));
      end
   end

endmodule

module pe_noc_interface #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 4,
   parameter int unsigned MyAddr    = 0,
   parameter int unsigned FifoDepth = 4
) (
   input  logic                           i_sclk,
   input  logic                           i_reset,
   input  logic [DataWidth-1:0]           i_pe_data,
   input  logic [AddrWidth-1:0]           i_pe_dest,
   input  logic                           i_pe_data_valid,
   output logic                           o_pe_data_ready,
   output logic [DataWidth-1:0]           o_pe_data,
   output logic                           o_pe_data_valid,
   input  logic                           i_pe_data_ready,
   output logic [DataWidth+AddrWidth-1:0] o_noc_data,
   output logic                           o_noc_data_valid,
   input  logic                           i_noc_data_ready,
   input  logic [DataWidth+AddrWidth-1:0] i_noc_data,
   input  logic                           i_noc_data_valid,
   output logic                           o_noc_data_ready,
   output logic [15:0]                    o_tx_count,
   output logic [15:0]                    o_rx_count,
   output logic [7:0]                     o_misroute_count
);

   localparam int unsigned FlitW = DataWidth + AddrWidth;

   logic tx_push;
   logic tx_pop;
   logic rx_xfer;
   logic addr_hit;
   logic rx_push;
   logic rx_pop;

   // Handshake qualification for all three interfaces.
   always_comb begin
      tx_push  = i_pe_data_valid & o_pe_data_ready;
      tx_pop   = o_noc_data_valid & i_noc_data_ready;
      rx_xfer  = i_noc_data_valid & o_noc_data_ready;
      addr_hit = (i_noc_data[FlitW-1:DataWidth] == AddrWidth'(MyAddr));
      rx_push  = rx_xfer & addr_hit;
      rx_pop   = o_pe_data_valid & i_pe_data_ready;
   end

   pe_noc_fifo #(.Width(FlitW), .Depth(FifoDepth)) u_tx_fifo (
      .clk      (i_sclk),
      .rst_n    (i_reset),
      .wr_en    (tx_push),
      .wr_data  ({i_pe_dest, i_pe_data}),
      .rd_en    (tx_pop),
      .rd_data  (o_noc_data),
      .rd_valid (o_noc_data_valid),
      .wr_ready (o_pe_data_ready)
   );

   pe_noc_fifo #(.Width(DataWidth), .Depth(FifoDepth)) u_rx_fifo (
      .clk      (i_sclk),
      .rst_n    (i_reset),
      .wr_en    (rx_push),
      .wr_data  (i_noc_data[DataWidth-1:0]),
      .rd_en    (rx_pop),
      .rd_data  (o_pe_data),
      .rd_valid (o_pe_data_valid),
      .wr_ready (o_noc_data_ready)
   );

   // Traffic counters: TX/RX wrap, misroute saturates.
   always_ff @(posedge i_sclk or negedge i_reset) begin
      if (!i_reset) begin
         o_tx_count       <= '0;
         o_rx_count       <= '0;
         o_misroute_count <= '0;
      end else begin
         if (tx_pop) o_tx_count <= o_tx_count + 16'd1;
         if (rx_pop) o_rx_count <= o_rx_count + 16'd1;
         if (rx_xfer && !addr_hit && (o_misroute_count != 8'hFF))
            o_misroute_count <= o_misroute_count + 8'd1;
      end
   end

endmodule

// File: doc/pe_noc_interface.md
Name: pe_noc_interface

Overview:
- Network interface between one processing element and one leaf port of the 16-PE BTree NoC.
- TX path: takes PE payload plus destination, builds a flit {dest, data}, buffers it, and drives it into the leaf port with valid/ready.
- RX path: accepts flits from the leaf port, checks the address field against this PE's ID, strips the address, and buffers the payload for the PE.
- One instance per PE, instantiated alongside the BTree top.

Parameters:
- DataWidth, 32, PE payload width in bits.
- AddrWidth, 4, destination field width; numPE = 2**AddrWidth.
- MyAddr, 0, this PE's network address (0..15).
- FifoDepth, 4, entries per TX and RX FIFO; power of two, at least 2.

Ports:
- i_sclk  in  1  clock.
- i_reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_pe_data  in  DataWidth  TX payload from PE.
- i_pe_dest  in  AddrWidth  TX destination address.
- i_pe_data_valid  in  1  TX payload valid.
- o_pe_data_ready  out  1  TX FIFO can accept.
- o_pe_data  out  DataWidth  RX payload to PE.
- o_pe_data_valid  out  1  RX payload valid.
- i_pe_data_ready  in  1  PE accepts RX payload.
- o_noc_data  out  DataWidth+AddrWidth  flit to leaf port.
- o_noc_data_valid  out  1  flit valid.
- i_noc_data_ready  in  1  leaf port accepts flit.
- i_noc_data  in  DataWidth+AddrWidth  flit from leaf port.
- i_noc_data_valid  in  1  incoming flit valid.
- o_noc_data_ready  out  1  RX side can accept flit.
- o_tx_count  out  16  flits sent to the network; wraps.
- o_rx_count  out  16  payloads delivered to the PE; wraps.
- o_misroute_count  out  8  dropped flits with wrong address; saturates at 255.

Behaviour:
- Flit format: bits [DataWidth+AddrWidth-1:DataWidth] = address, [DataWidth-1:0] = data.
- Transfer rule: a transfer occurs on a rising edge where valid & ready; this holds on all three interfaces.
- Valid rule: valid never depends combinationally on ready.
- Reset (i_reset = 0, async):
  - Both FIFOs empty; all counters 0.
  - o_noc_data_valid = 0, o_pe_data_valid = 0, o_pe_data_ready = 0, o_noc_data_ready = 0, data outputs 0.
  - Both ready outputs are registered and go to 1 on the first i_sclk edge after reset release.
  - Reset mid-operation discards all buffered flits and payloads; no partial transfers.
- TX FIFO:
  - Push {i_pe_dest, i_pe_data} on PE transfer.
  - o_pe_data_ready = registered not-full, computed so no overflow occurs. Registering ready means the FIFO may report not-ready one entry early, which is acceptable.
  - First-word-fall-through output: o_noc_data = head entry, o_noc_data_valid = not-empty.
  - Pop on NoC transfer; o_tx_count increments on each pop.
  - Latency: a flit pushed at edge N is valid on o_noc_data after edge N when the FIFO was empty.
  - Push and pop in the same cycle keep occupancy unchanged, including at full-minus-one and at one entry.
  - Pointers wrap modulo FifoDepth.
  - dest == MyAddr is legal; the flit goes out and the network routes it back.
- RX path:
  - On NoC transfer, if address field == MyAddr, write the data field into the RX FIFO.
  - Otherwise drop the flit and increment o_misroute_count, holding at 255.
  - A dropped flit is still consumed; ready is unaffected.
  - o_noc_data_ready = registered not-full, same rule as TX.
  - o_pe_data_valid = RX not-empty; o_pe_data = head entry.
  - Pop on PE transfer; o_rx_count increments on each pop.
  - Simultaneous write and pop behave as on TX.
- Data stability: o_noc_data and o_pe_data stay stable while valid is high and ready is low.
- Counter wrap: o_tx_count and o_rx_count wrap 65535 -> 0.
- Independence: TX and RX paths are independent and may transfer in the same cycle.

Test Plan:
- Reset, then single TX: MyAddr=0, PE sends data=0xDEADBEEF, dest=5 -> one cycle later o_noc_data=0x5DEADBEEF with valid=1; pop; o_tx_count=1.
- TX backpressure: i_noc_data_ready=0, PE sends 6 flits -> o_pe_data_ready drops after at most 4 accepted; release ready -> flits emerge in order with no loss or duplication; o_tx_count=number accepted.
- RX filter: MyAddr=3, inject 0x3_00000011 then 0x7_00000022 then 0x3_00000033 -> PE receives 0x11 then 0x33; o_misroute_count=1; o_rx_count=2.
- RX full: i_pe_data_ready=0, inject 8 matching flits -> o_noc_data_ready deasserts, 4 stored, none corrupted; drain -> order preserved.
- Concurrency and reset: continuous push/pop on both paths for 100 cycles -> occupancy constant, counts match. Assert i_reset=0 mid-stream -> all valids 0 immediately, counters 0, readies return 1 one edge after release.
- Saturation: inject 300 misrouted flits -> o_misroute_count holds at 255.
